// File: rtl/jedro_1_defines_pkg.sv
// Shared decode definitions: ALU operations, immediate formats, RV32I opcodes.
package jedro_1_defines;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Base ALU operation selected by funct3 for OP / OP-IMM (funct7 refines 0 and 5).
    function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/jedro_1_imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from instr[31].
module jedro_1_imm_gen
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    input  imm_type_e             imm_type,
    output logic [DATA_WIDTH-1:0] imm
);

    // Select the immediate layout for the requested format.
    always_comb begin
        imm = {{(DATA_WIDTH-11){instr[31]}}, instr[30:20]};
        case (imm_type)
            IMM_S:   imm = {{(DATA_WIDTH-11){instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{(DATA_WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[DATA_WIDTH-1:12], 12'b0};
            IMM_J:   imm = {{(DATA_WIDTH-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{(DATA_WIDTH-11){instr[31]}}, instr[30:20]};
        endcase
    end

endmodule

// File: rtl/jedro_1_decoder.sv
// Decode stage: registers decoded RV32I fields, hands them to execute over
// valid/ready and paces the fetch unit with a refill blanking window.
module jedro_1_decoder
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FETCH_LAT      = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     instr_i,
    input  logic                      instr_valid_i,
    output logic                      get_next_instr_o,
    input  logic                      flush_i,
    input  logic                      dec_ready_i,
    output logic                      dec_valid_o,
    output alu_op_e                   alu_op_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      rd_we_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic                      use_imm_o,
    output logic                      is_load_o,
    output logic                      is_store_o,
    output logic                      is_branch_o,
    output logic                      is_jump_o,
    output logic [2:0]                funct3_o,
    output logic                      illegal_o
);

    typedef enum logic [1:0] {S_IDLE, S_VALID, S_REFILL} state_e;

    state_e    state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic      load_en;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    alu_op_e               d_alu;
    imm_type_e             d_imm_type;
    logic [DATA_WIDTH-1:0] d_imm;
    logic d_use_imm, d_rd_we, d_load, d_store, d_branch, d_jump, d_illegal;

    jedro_1_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr    (instr_i),
        .imm_type (d_imm_type),
        .imm      (d_imm)
    );

    // Decode the incoming word into control fields; illegal words suppress side effects.
    always_comb begin
        d_alu      = ALU_ADD;
        d_imm_type = IMM_I;
        d_use_imm  = 1'b0;
        d_rd_we    = 1'b0;
        d_load     = 1'b0;
        d_store    = 1'b0;
        d_branch   = 1'b0;
        d_jump     = 1'b0;
        d_illegal  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                d_rd_we   = 1'b1;
                d_use_imm = (opcode == OPC_OPIMM);
                d_alu     = funct3_to_alu(funct3);
                // funct7 only qualifies register ops and the immediate shifts
                if (opcode == OPC_OP || funct3 == 3'd1 || funct3 == 3'd5) begin
                    if (funct7 == 7'b0100000 && funct3 == 3'd5)
                        d_alu = ALU_SRA;
                    else if (funct7 == 7'b0100000 && funct3 == 3'd0 && opcode == OPC_OP)
                        d_alu = ALU_SUB;
                    else if (funct7 != 7'b0000000)
                        d_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                d_load    = 1'b1;
                d_rd_we   = 1'b1;
                d_use_imm = 1'b1;
                d_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                d_store    = 1'b1;
                d_use_imm  = 1'b1;
                d_imm_type = IMM_S;
                d_illegal  = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                d_branch   = 1'b1;
                d_imm_type = IMM_B;
                d_illegal  = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_JAL: begin
                d_jump     = 1'b1;
                d_rd_we    = 1'b1;
                d_imm_type = IMM_J;
            end
            OPC_JALR: begin
                d_jump    = 1'b1;
                d_rd_we   = 1'b1;
                d_use_imm = 1'b1;
            end
            OPC_LUI: begin
                d_alu      = ALU_PASS_B;
                d_rd_we    = 1'b1;
                d_use_imm  = 1'b1;
                d_imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                d_rd_we    = 1'b1;
                d_use_imm  = 1'b1;
                d_imm_type = IMM_U;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: d_illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11 || instr_i == '0 || instr_i == '1)
            d_illegal = 1'b1;
        if (d_illegal) begin
            d_rd_we  = 1'b0;
            d_load   = 1'b0;
            d_store  = 1'b0;
            d_branch = 1'b0;
            d_jump   = 1'b0;
        end
        if (instr_i[11:7] == 5'd0)
            d_rd_we = 1'b0;
    end

    // Next-state logic: accept in idle, hand off in valid, blank during refill; flush overrides.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_en    = 1'b0;
        get_next_instr_o = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (instr_valid_i && !flush_i) begin
                    load_en    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                get_next_instr_o = dec_ready_i;
                if (dec_ready_i) begin
                    state_next = S_REFILL;
                    cnt_next   = 3'(FETCH_LAT - 1);
                end
            end
            S_REFILL: begin
                if (cnt_reg == 3'd0) state_next = S_IDLE;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush_i) begin
            state_next = S_IDLE;
            cnt_next   = 3'd0;
        end
    end

    assign dec_valid_o = (state_reg == S_VALID);

    // State and refill counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Decoded field registers, loaded only when an instruction is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_op_o    <= ALU_ADD;
            rs1_addr_o  <= '0;
            rs2_addr_o  <= '0;
            rd_addr_o   <= '0;
            rd_we_o     <= 1'b0;
            imm_o       <= '0;
            use_imm_o   <= 1'b0;
            is_load_o   <= 1'b0;
            is_store_o  <= 1'b0;
            is_branch_o <= 1'b0;
            is_jump_o   <= 1'b0;
            funct3_o    <= 3'd0;
            illegal_o   <= 1'b0;
        end else if (load_en) begin
            alu_op_o    <= d_alu;
            rs1_addr_o  <= instr_i[15 +: REG_ADDR_WIDTH];
            rs2_addr_o  <= instr_i[20 +: REG_ADDR_WIDTH];
            rd_addr_o   <= instr_i[7 +: REG_ADDR_WIDTH];
            rd_we_o     <= d_rd_we;
            imm_o       <= d_imm;
            use_imm_o   <= d_use_imm;
            is_load_o   <= d_load;
            is_store_o  <= d_store;
            is_branch_o <= d_branch;
            is_jump_o   <= d_jump;
            funct3_o    <= funct3;
            illegal_o   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Randomised scoreboard bench for the decode stage with a behavioural RV32I reference.
module tb_jedro_1_decoder;
    import jedro_1_defines::*;

    localparam int FL = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        get_next_instr_o;
    logic        flush_i = 1'b0;
    logic        dec_ready_i = 1'b0;
    logic        dec_valid_o;
    alu_op_e     alu_op_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        rd_we_o;
    logic [31:0] imm_o;
    logic        use_imm_o, is_load_o, is_store_o, is_branch_o, is_jump_o;
    logic [2:0]  funct3_o;
    logic        illegal_o;

    jedro_1_decoder #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FETCH_LAT(FL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .get_next_instr_o(get_next_instr_o), .flush_i(flush_i), .dec_ready_i(dec_ready_i),
        .dec_valid_o(dec_valid_o), .alu_op_o(alu_op_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .imm_o(imm_o),
        .use_imm_o(use_imm_o), .is_load_o(is_load_o), .is_store_o(is_store_o),
        .is_branch_o(is_branch_o), .is_jump_o(is_jump_o), .funct3_o(funct3_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        illegal, rd_we, ld, st, br, jp;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [3:0]  alu;   logic alu_chk;
        logic [31:0] imm;   logic imm_chk;
        logic        use_imm; logic use_chk;
    } exp_t;

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];
    logic [31:0] dir_q[$];
    logic [6:0]  opc_list [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                   7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    logic [3:0]  base_alu [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                  ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode built from the RV32I encoding tables.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [6:0]  opc = w[6:0];
        logic [2:0]  f3  = w[14:12];
        logic [6:0]  f7  = w[31:25];
        logic [31:0] sx  = 32'($signed(w) >>> 31);
        logic [31:0] ii  = 32'($signed(w) >>> 20);
        logic [31:0] is_ = (ii & ~32'h1F) | 32'(w[11:7]);
        logic [31:0] ib  = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        logic [31:0] iu  = w & 32'hFFFFF000;
        logic [31:0] ij  = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        logic legal = 1'b1;
        logic we = 1'b0;
        e = '{instr: w, rd: w[11:7], rs1: w[19:15], rs2: w[24:20], f3: f3, default: '0};
        case (opc)
            7'h33: begin
                we = 1; e.use_chk = 1; e.use_imm = 0; e.alu_chk = 1; e.alu = base_alu[f3];
                if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) e.alu = (f3 == 0) ? ALU_SUB : ALU_SRA;
                else if (f7 != 0) legal = 0;
            end
            7'h13: begin
                we = 1; e.use_chk = 1; e.use_imm = 1; e.alu_chk = 1; e.alu = base_alu[f3];
                e.imm_chk = 1; e.imm = ii;
                if (f3 == 1 && f7 != 0) legal = 0;
                if (f3 == 5) begin
                    if (f7 == 7'h20) e.alu = ALU_SRA;
                    else if (f7 != 0) legal = 0;
                end
            end
            7'h03: begin e.ld = 1; we = 1; e.imm_chk = 1; e.imm = ii; legal = f3 inside {0,1,2,4,5}; end
            7'h23: begin e.st = 1; e.imm_chk = 1; e.imm = is_; legal = f3 inside {0,1,2}; end
            7'h63: begin e.br = 1; e.imm_chk = 1; e.imm = ib; legal = !(f3 inside {2,3}); end
            7'h6F: begin e.jp = 1; we = 1; e.imm_chk = 1; e.imm = ij; end
            7'h67: begin e.jp = 1; we = 1; e.imm_chk = 1; e.imm = ii; end
            7'h37: begin we = 1; e.alu_chk = 1; e.alu = ALU_PASS_B; e.use_chk = 1; e.use_imm = 1;
                         e.imm_chk = 1; e.imm = iu; end
            7'h17: begin we = 1; e.use_chk = 1; e.use_imm = 1; e.imm_chk = 1; e.imm = iu; end
            7'h0F, 7'h73: ;
            default: legal = 0;
        endcase
        if (w == 32'h0 || w == 32'hFFFFFFFF) legal = 0;
        if (!legal) begin
            e.illegal = 1; we = 0; e.ld = 0; e.st = 0; e.br = 0; e.jp = 0;
            e.alu_chk = 0; e.imm_chk = 0; e.use_chk = 0;
        end
        e.rd_we = we && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opc_list[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    // Monitor: pops an expectation when the DUT presents, checks fields every valid cycle.
    initial begin
        exp_t cur;
        logic have_cur = 1'b0;
        logic prev_v   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                prev_v = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (dec_valid_o && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++; have_cur = 1'b0;
                        $display("FAIL unexpected_present: got instr with none expected");
                    end else begin
                        cur = sb_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (dec_valid_o && have_cur) begin
                    chk($sformatf("illegal@%h", cur.instr), 32'(illegal_o), 32'(cur.illegal));
                    chk($sformatf("rd_we@%h", cur.instr), 32'(rd_we_o), 32'(cur.rd_we));
                    chk($sformatf("class@%h", cur.instr),
                        {28'b0, is_load_o, is_store_o, is_branch_o, is_jump_o},
                        {28'b0, cur.ld, cur.st, cur.br, cur.jp});
                    chk($sformatf("regs@%h", cur.instr), {17'b0, rd_addr_o, rs1_addr_o, rs2_addr_o},
                        {17'b0, cur.rd, cur.rs1, cur.rs2});
                    chk($sformatf("funct3@%h", cur.instr), 32'(funct3_o), 32'(cur.f3));
                    if (cur.alu_chk) chk($sformatf("alu_op@%h", cur.instr), 32'(alu_op_o), 32'(cur.alu));
                    if (cur.imm_chk) chk($sformatf("imm@%h", cur.instr), imm_o, cur.imm);
                    if (cur.use_chk) chk($sformatf("use_imm@%h", cur.instr), 32'(use_imm_o), 32'(cur.use_imm));
                end
                prev_v = dec_valid_o;
            end
        end
    end

    // Transaction-level timing model for the driver.
    logic holding = 1'b0;
    int   blank_until = 0;
    int   cyc = 0;

    // One cycle: drive at the falling edge, check handshake outputs, advance the model.
    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        logic hs, acc;
        instr_valid_i = v; instr_i = w; dec_ready_i = rdy; flush_i = fl;
        #1;
        hs  = holding && rdy;
        acc = !holding && (cyc >= blank_until) && v && !fl;
        chk("dec_valid", 32'(dec_valid_o), 32'(holding));
        chk("get_next", 32'(get_next_instr_o), 32'(hs));
        if (fl) begin
            holding = 1'b0; blank_until = cyc + 1;
        end else if (hs) begin
            holding = 1'b0; blank_until = cyc + FL + 1;
        end else if (acc) begin
            holding = 1'b1;
            sb_q.push_back(ref_decode(w));
            $display("accept cyc=%0d instr=%h", cyc, w);
            if (dir_q.size() != 0) void'(dir_q.pop_front());
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(dec_valid_o), 32'd0);
        chk({tag, "_getnext"}, 32'(get_next_instr_o), 32'd0);
        chk({tag, "_fields"},
            {8'b0, 4'(alu_op_o), rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o},
            32'd0);
        chk({tag, "_flags"},
            {25'b0, rd_we_o, use_imm_o, is_load_o, is_store_o, is_branch_o, is_jump_o, illegal_o},
            32'd0);
        chk({tag, "_imm"}, imm_o, 32'd0);
    endtask

    initial begin
        int guard;
        logic [31:0] w;
        dir_q = '{32'h00500093, 32'h402081B3, 32'hFE000EE3, 32'h123452B7,
                  32'hFFFFFFFF, 32'h00000000, 32'h00500013};
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        // Directed words with random backpressure and no flush.
        guard = 0;
        while (dir_q.size() != 0 && guard < 500) begin
            step(1'b1, dir_q[0], ($urandom_range(0, 3) == 0), 1'b0);
            guard++;
        end
        chk("directed_drained", 32'(dir_q.size()), 32'd0);

        // Random traffic including flushes in every state.
        for (int i = 0; i < 3000; i++) begin
            w = rand_instr();
            step(($urandom_range(0, 4) != 0), w, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset while an instruction is presented.
        guard = 0;
        while (!holding && guard < 20) begin
            step(1'b1, 32'h00700113, 1'b0, 1'b0);
            guard++;
        end
        chk("pre_reset_valid", 32'(dec_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1 check_all_zero("async_reset");
        holding = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        blank_until = cyc;

        dir_q.push_back(32'h00500093);
        for (int i = 0; i < 20; i++) begin
            if (dir_q.size() != 0) step(1'b1, dir_q[0], 1'b0, 1'b0);
            else                   step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("post_reset_drained", 32'(dir_q.size()), 32'd0);
        @(posedge clk_i);
        #2;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
